palette_loader: RTL and testbench

//  Downstream of the top-level command dispatcher. Runs on CMD_I_SetPalette.

---
 rtl/palette_loader_if.sv | 33 +++
 rtl/palette_loader.sv | 179 +++++++++++++++++
 tb/tb_palette_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/palette_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : palette_loader_if
//  Brief    : Avalon-MM byte-wide memory port used by the palette loader.
//  Revision : 1.0 - initial release
// ============================================================================
interface palette_loader_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [7:0]  mem_readdata;
    logic        mem_write;
    logic [7:0]  mem_writedata;

    modport master (
        output mem_address,
        output mem_read,
        output mem_write,
        output mem_writedata,
        input  mem_waitrequest,
        input  mem_readdata
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        input  mem_write,
        input  mem_writedata,
        output mem_waitrequest,
        output mem_readdata
    );
endinterface
`default_nettype wire

// File: rtl/palette_loader.sv
`default_nettype none
// ============================================================================
//  Module   : palette_loader
//  Brief    : Fetches one PLAYPAL palette over Avalon-MM, stores it as RGB565
//             in a local RAM and serves a 1-cycle index lookup port.
//  Revision : 1.0 - initial release
// ============================================================================
module palette_loader #(
    parameter int NUM_ENTRIES    = 256,
    parameter int NUM_PALETTES   = 14,
    parameter int BASE_PARAM_IDX = 0,
    parameter int SEL_PARAM_IDX  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             processing,
    input  logic [7:0][31:0] hps_params,
    palette_loader_if.master mem,
    input  logic [7:0]       lookup_index,
    output logic [15:0]      lookup_rgb565,
    output logic             pal_valid,
    output logic             pal_error,
    output logic [6:0]       debug_seg_export
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_FETCH = 3'b010,
        S_DONE  = 3'b100
    } state_t;

    localparam int                 c_ENT_W     = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [c_ENT_W-1:0] c_LAST_ENT  = c_ENT_W'(NUM_ENTRIES - 1);
    localparam logic [31:0]        c_PAL_BYTES = 32'(3 * NUM_ENTRIES);
    localparam logic [31:0]        c_NUM_PAL   = 32'(NUM_PALETTES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_addr;
    logic [c_ENT_W-1:0] r_ent_cnt;
    logic [1:0]         r_comp_cnt;
    logic [7:0]         r_red;
    logic [7:0]         r_grn;
    logic               r_pal_valid;
    logic               r_pal_error;
    logic [15:0]        r_lookup;
    logic [15:0]        r_ram [NUM_ENTRIES];

    logic [31:0]        w_base;
    logic [3:0]         w_sel;
    logic               w_sel_bad;
    logic               w_accept;
    logic               w_ram_we;
    logic               w_last_byte;
    logic               w_start_load;
    logic               w_reject;
    logic [15:0]        w_ram_wdata;
    logic               w_unused;

    assign w_base      = hps_params[BASE_PARAM_IDX];
    assign w_sel       = hps_params[SEL_PARAM_IDX][3:0];
    assign w_sel_bad   = ({28'd0, w_sel} >= c_NUM_PAL);
    assign w_accept    = (r_state == S_FETCH) && !mem.mem_waitrequest;
    assign w_ram_we    = w_accept && (r_comp_cnt == 2'd2);
    assign w_last_byte = w_ram_we && (r_ent_cnt == c_LAST_ENT);
    // Blue comes straight off the bus so the entry is written on its accept.
    assign w_ram_wdata = {r_red[7:3], r_grn[7:2], mem.mem_readdata[7:3]};

    always_comb begin
        w_state_nxt  = r_state;
        w_start_load = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_sel_bad) begin
                        w_reject    = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_start_load = 1'b1;
                        w_state_nxt  = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                // An abort waits for the outstanding read to be accepted.
                if (w_last_byte) begin
                    w_state_nxt = S_DONE;
                end else if (w_accept && !start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_ent_cnt   <= '0;
            r_comp_cnt  <= '0;
            r_red       <= '0;
            r_grn       <= '0;
            r_pal_valid <= 1'b0;
            r_pal_error <= 1'b0;
        end else begin
            if (w_start_load) begin
                r_addr      <= w_base + (32'(w_sel) * c_PAL_BYTES);
                r_ent_cnt   <= '0;
                r_comp_cnt  <= '0;
                r_pal_valid <= 1'b0;
                r_pal_error <= 1'b0;
            end
            if (w_reject) begin
                r_pal_error <= 1'b1;
            end
            if (w_accept) begin
                r_addr <= r_addr + 32'd1;
                case (r_comp_cnt)
                    2'd0:    r_red <= mem.mem_readdata;
                    2'd1:    r_grn <= mem.mem_readdata;
                    default: ;
                endcase
                if (r_comp_cnt == 2'd2) begin
                    r_comp_cnt <= '0;
                    r_ent_cnt  <= r_ent_cnt + 1'b1;
                end else begin
                    r_comp_cnt <= r_comp_cnt + 2'd1;
                end
            end
            if (w_last_byte) begin
                r_pal_valid <= 1'b1;
            end
        end
    end

    // Palette storage keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[r_ent_cnt] <= w_ram_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lookup <= '0;
        end else begin
            r_lookup <= r_ram[lookup_index];
        end
    end

    assign processing        = (r_state == S_FETCH) || ((r_state == S_IDLE) && start);
    assign mem.mem_read      = (r_state == S_FETCH);
    assign mem.mem_address   = r_addr;
    assign mem.mem_write     = 1'b0;
    assign mem.mem_writedata = 8'd0;
    assign lookup_rgb565     = r_lookup;
    assign pal_valid         = r_pal_valid;
    assign pal_error         = r_pal_error;
    assign debug_seg_export  = {4'd0, r_state};

    assign w_unused = &{1'b0, hps_params};

endmodule
`default_nettype wire

// File: tb/tb_palette_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_palette_loader
//  Brief    : Directed self-checking bench for palette_loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_palette_loader;

    logic             clk     = 1'b0;
    logic             clk_en  = 1'b0;
    logic             reset_n = 1'b1;
    logic             start   = 1'b0;
    logic             wreq    = 1'b0;
    logic [7:0][31:0] hps     = '0;
    logic [7:0]       lookup_index = 8'd0;
    logic             processing;
    logic [15:0]      lookup_rgb565;
    logic             pal_valid;
    logic             pal_error;
    logic [6:0]       debug_seg;

    int n_vec = 0;
    int n_bad = 0;

    palette_loader_if mif ();

    always #5 if (clk_en) clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'h0800_0030: byte_at = 8'hF8;
            32'h0800_0031: byte_at = 8'h00;
            32'h0800_0032: byte_at = 8'h08;
            default:       byte_at = a[7:0] ^ {a[10:8], a[15:11]} ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [15:0] golden(input logic [31:0] pal_addr, input int i);
        logic [7:0] r, g, b;
        r = byte_at(pal_addr + 32'(3 * i));
        g = byte_at(pal_addr + 32'(3 * i + 1));
        b = byte_at(pal_addr + 32'(3 * i + 2));
        golden = {r[7:3], g[7:2], b[7:3]};
    endfunction

    assign mif.mem_waitrequest = wreq;
    assign mif.mem_readdata    = byte_at(mif.mem_address);

    palette_loader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .processing       (processing),
        .hps_params       (hps),
        .mem              (mif),
        .lookup_index     (lookup_index),
        .lookup_rgb565    (lookup_rgb565),
        .pal_valid        (pal_valid),
        .pal_error        (pal_error),
        .debug_seg_export (debug_seg)
    );

    task automatic start_load(input logic [31:0] base, input logic [3:0] sel);
        @(negedge clk);
        hps[0] = base;
        hps[1] = {28'd0, sel};
        start  = 1'b1;
    endtask

    // Drives waitrequest and gathers read statistics until processing falls.
    task automatic run_fetch(input int wmode, input int stop_after,
                             output int n_acc, output int gap_err, output int stall_err,
                             output logic [31:0] a_first, output logic [31:0] a_last,
                             output bit last_acc);
        logic [31:0] a_prev;
        bit          stalled;
        int          cyc;
        n_acc = 0; gap_err = 0; stall_err = 0; a_first = '0; a_last = '0;
        last_acc = 0; stalled = 0; a_prev = '0; cyc = 0;
        while (cyc < 5000) begin
            @(negedge clk);
            wreq = (wmode == 0) ? 1'b0 : (wmode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            cyc++;
            if (stalled && (mif.mem_read !== 1'b1 || mif.mem_address !== a_prev)) stall_err++;
            if (!processing) break;
            last_acc = mif.mem_read && !wreq;
            if (mif.mem_read) begin
                if (!wreq) begin
                    if (n_acc == 0) a_first = mif.mem_address;
                    else if (mif.mem_address !== a_last + 32'd1) gap_err++;
                    a_last = mif.mem_address;
                    n_acc++;
                    if (stop_after > 0 && n_acc == stop_after) break;
                end
                stalled = wreq;
                a_prev  = mif.mem_address;
            end else begin
                stalled = 0;
            end
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); #1;
        n_vec++;
        if (debug_seg !== 7'h01) begin
            n_bad++; $display("FAIL release_to_idle: got %h want 01", debug_seg);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #7;
        n_vec++;
        if ({mif.mem_read, processing, pal_valid, pal_error} !== 4'b0000 || lookup_rgb565 !== 16'h0) begin
            n_bad++; $display("FAIL reset_noclk: got rd/proc/val/err=%b lut=%h want 0000/0000",
                              {mif.mem_read, processing, pal_valid, pal_error}, lookup_rgb565);
        end
        n_vec++;
        if (mif.mem_address !== 32'h0 || debug_seg !== 7'h01) begin
            n_bad++; $display("FAIL reset_addr_state: got %h/%h want 0/01", mif.mem_address, debug_seg);
        end
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({mif.mem_read, processing, pal_valid, pal_error} !== 4'b0000 || lookup_rgb565 !== 16'h0) begin
            n_bad++; $display("FAIL reset_clk: got rd/proc/val/err=%b lut=%h want 0000/0000",
                              {mif.mem_read, processing, pal_valid, pal_error}, lookup_rgb565);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic_load();
        int n_acc, gap, stall; logic [31:0] af, al; bit lacc;
        start_load(32'h0800_0000, 4'd0);
        run_fetch(0, 0, n_acc, gap, stall, af, al, lacc);
        n_vec++;
        if (n_acc != 768 || af !== 32'h0800_0000 || al !== 32'h0800_02FF || gap != 0) begin
            n_bad++; $display("FAIL basic_reads: got n=%0d first=%h last=%h gaps=%0d want 768/08000000/080002ff/0",
                              n_acc, af, al, gap);
        end
        n_vec++;
        if (!lacc || pal_valid !== 1'b1 || pal_error !== 1'b0 || debug_seg !== 7'h04) begin
            n_bad++; $display("FAIL basic_done: got lastacc=%0d val=%b err=%b st=%h want 1/1/0/04",
                              lacc, pal_valid, pal_error, debug_seg);
        end
        lookup_index = 8'h10;
        @(negedge clk); #1;
        n_vec++;
        if (lookup_rgb565 !== 16'hF801) begin
            n_bad++; $display("FAIL lookup_0x10: got %h want f801", lookup_rgb565);
        end
        drop_start();
    endtask

    task automatic test_bad_sel();
        int nproc, nread;
        nproc = 0; nread = 0;
        @(negedge clk);
        hps[1] = 32'd14;
        start  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (processing) nproc++;
            if (mif.mem_read) nread++;
            @(negedge clk);
        end
        n_vec++;
        if (nproc != 1 || nread != 0) begin
            n_bad++; $display("FAIL badsel_activity: got proc=%0d reads=%0d want 1/0", nproc, nread);
        end
        n_vec++;
        if (pal_error !== 1'b1 || pal_valid !== 1'b1 || debug_seg !== 7'h04) begin
            n_bad++; $display("FAIL badsel_flags: got err=%b val=%b st=%h want 1/1/04", pal_error, pal_valid, debug_seg);
        end
        drop_start();
    endtask

    task automatic test_contiguous();
        int n_acc, gap, stall; logic [31:0] af, al; bit lacc;
        start_load(32'h0000_1000, 4'd13);
        run_fetch(0, 0, n_acc, gap, stall, af, al, lacc);
        n_vec++;
        if (n_acc != 768 || af !== 32'h0000_3700 || al !== 32'h0000_39FF || gap != 0) begin
            n_bad++; $display("FAIL sel13_reads: got n=%0d first=%h last=%h gaps=%0d want 768/3700/39ff/0",
                              n_acc, af, al, gap);
        end
        n_vec++;
        if (pal_error !== 1'b0 || pal_valid !== 1'b1) begin
            n_bad++; $display("FAIL sel13_flags: got err=%b val=%b want 0/1", pal_error, pal_valid);
        end
        drop_start();
    endtask

    task automatic test_random_wait();
        int n_acc, gap, stall; logic [31:0] af, al; bit lacc;
        start_load(32'h0010_0005, 4'd5);
        run_fetch(1, 0, n_acc, gap, stall, af, al, lacc);
        wreq = 1'b0;
        n_vec++;
        if (n_acc != 768 || stall != 0 || gap != 0 || af !== 32'h0010_0F05) begin
            n_bad++; $display("FAIL rand_reads: got n=%0d stall=%0d gaps=%0d first=%h want 768/0/0/00100f05",
                              n_acc, stall, gap, af);
        end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            lookup_index = 8'(i);
            @(negedge clk); #1;
            n_vec++;
            if (lookup_rgb565 !== golden(32'h0010_0F05, i)) begin
                n_bad++; $display("FAIL ram_entry[%0d]: got %h want %h", i, lookup_rgb565, golden(32'h0010_0F05, i));
            end
        end
        drop_start();
    endtask

    task automatic test_reset_mid_fetch();
        int n_acc, gap, stall; logic [31:0] af, al; bit lacc;
        start_load(32'h0800_0000, 4'd0);
        run_fetch(0, 50, n_acc, gap, stall, af, al, lacc);
        #2;
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        n_vec++;
        if ({mif.mem_read, processing, pal_valid, pal_error} !== 4'b0000 || lookup_rgb565 !== 16'h0 ||
            mif.mem_address !== 32'h0 || debug_seg !== 7'h01) begin
            n_bad++; $display("FAIL reset_mid_fetch: got rd/proc/val/err=%b lut=%h addr=%h st=%h want 0000/0/0/01",
                              {mif.mem_read, processing, pal_valid, pal_error}, lookup_rgb565, mif.mem_address, debug_seg);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_abort_restart();
        int n_acc, gap, stall, bad_hold; logic [31:0] af, al; bit lacc;
        bad_hold = 0;
        start_load(32'h0000_2000, 4'd2);
        run_fetch(0, 300, n_acc, gap, stall, af, al, lacc);
        @(negedge clk);
        wreq  = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (mif.mem_read !== 1'b1 || mif.mem_address !== 32'h0000_272C || debug_seg !== 7'h02) bad_hold++;
            @(negedge clk);
        end
        wreq = 1'b0;
        #1;
        n_vec++;
        if (bad_hold != 0 || mif.mem_read !== 1'b1 || mif.mem_address !== 32'h0000_272C) begin
            n_bad++; $display("FAIL abort_hold: got badcyc=%0d rd=%b addr=%h want 0/1/0000272c",
                              bad_hold, mif.mem_read, mif.mem_address);
        end
        @(negedge clk); #1;
        n_vec++;
        if (debug_seg !== 7'h01 || mif.mem_read !== 1'b0 || processing !== 1'b0 || pal_valid !== 1'b0) begin
            n_bad++; $display("FAIL abort_idle: got st=%h rd=%b proc=%b val=%b want 01/0/0/0",
                              debug_seg, mif.mem_read, processing, pal_valid);
        end
        start_load(32'h0000_2000, 4'd2);
        run_fetch(0, 0, n_acc, gap, stall, af, al, lacc);
        n_vec++;
        if (n_acc != 768 || af !== 32'h0000_2600 || gap != 0 || pal_valid !== 1'b1) begin
            n_bad++; $display("FAIL restart_load: got n=%0d first=%h gaps=%0d val=%b want 768/2600/0/1",
                              n_acc, af, gap, pal_valid);
        end
        drop_start();
    endtask

    initial begin
        #2;
        test_reset();
        test_basic_load();
        test_bad_sel();
        test_contiguous();
        test_random_wait();
        test_reset_mid_fetch();
        test_abort_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
